test: RTL and testbench

TEST -- requirements
Module: test

---
 rtl/test.sv | 156 +++++++++++++++
 tb/tb_test.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/test.sv
// PS/2 keyboard receiver and scan-code decoder: pulses set_signal/reset_signal on configured
// make codes and latches the last accepted make code on inForFSM.
module test #(
  parameter logic [7:0]  SET_CODE       = 8'h29,
  parameter logic [7:0]  RESET_CODE     = 8'h0D,
  parameter logic [7:0]  STOP_CODE      = 8'hF0,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PS2_clk,
  input  logic       PS2_dat,
  output logic [7:0] inForFSM,
  output logic       set_signal,
  output logic       reset_signal
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;
  localparam logic [1:0] StStop   = 2'd3;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] ToMax = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] ExtCode = 8'hE0;

  logic          kclk_meta_q, kclk_sync_q, kclk_prev_q;
  logic          kdat_meta_q, kdat_sync_q;
  logic          fall;

  logic [1:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic          ready_q, ready_d;

  logic          brk_q, brk_d;
  logic [7:0]    key_q, key_d;
  logic          set_q, set_d;
  logic          rsig_q, rsig_d;

  // Synchronizers idle high so releasing reset never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_meta_q <= 1'b1;
      kclk_sync_q <= 1'b1;
      kclk_prev_q <= 1'b1;
      kdat_meta_q <= 1'b1;
      kdat_sync_q <= 1'b1;
    end else begin
      kclk_meta_q <= PS2_clk;
      kclk_sync_q <= kclk_meta_q;
      kclk_prev_q <= kclk_sync_q;
      kdat_meta_q <= PS2_dat;
      kdat_sync_q <= kdat_meta_q;
    end
  end

  assign fall = kclk_prev_q & ~kclk_sync_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    to_d    = to_q;
    ready_d = 1'b0;
    if (fall) begin
      to_d = '0;
      unique case (state_q)
        StIdle: begin
          if (!kdat_sync_q) begin
            state_d = StData;
            cnt_d   = 3'd0;
          end
        end
        StData: begin
          shift_d = {kdat_sync_q, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = kdat_sync_q;
          state_d = StStop;
        end
        StStop: begin
          ready_d = kdat_sync_q & (par_q == ~^shift_q);
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      // Stalled device: drop the partial byte and wait for a fresh start bit.
      if (to_q == ToMax) begin
        state_d = StIdle;
        to_d    = '0;
        cnt_d   = 3'd0;
        shift_d = 8'h00;
      end else begin
        to_d = to_q + TW'(1);
      end
    end
  end

  always_comb begin
    brk_d  = brk_q;
    key_d  = key_q;
    set_d  = 1'b0;
    rsig_d = 1'b0;
    if (ready_q) begin
      if (shift_q == STOP_CODE) begin
        brk_d = 1'b1;
      end else if (shift_q != ExtCode) begin
        if (brk_q) begin
          brk_d = 1'b0;
        end else begin
          key_d  = shift_q;
          set_d  = (shift_q == SET_CODE);
          rsig_d = (shift_q == RESET_CODE);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      to_q    <= '0;
      ready_q <= 1'b0;
      brk_q   <= 1'b0;
      key_q   <= 8'h00;
      set_q   <= 1'b0;
      rsig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      to_q    <= to_d;
      ready_q <= ready_d;
      brk_q   <= brk_d;
      key_q   <= key_d;
      set_q   <= set_d;
      rsig_q  <= rsig_d;
    end
  end

  assign inForFSM     = key_q;
  assign set_signal   = set_q;
  assign reset_signal = rsig_q;

endmodule

// File: tb/tb_test.sv
// Bench for test: drives PS/2 frames and checks outputs against a frame-level decoder model.
module tb_test;

  logic       clk;
  logic       rst_n;
  logic       PS2_clk;
  logic       PS2_dat;
  logic [7:0] inForFSM;
  logic       set_signal;
  logic       reset_signal;

  test dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PS2_clk      (PS2_clk),
    .PS2_dat      (PS2_dat),
    .inForFSM     (inForFSM),
    .set_signal   (set_signal),
    .reset_signal (reset_signal)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int         errs = 0;
  int         checks = 0;
  logic [7:0] exp_in = 8'h00;
  bit         brk = 1'b0;
  bit         window = 1'b0;
  int         set_cnt = 0;
  int         rst_cnt = 0;
  logic       set_prev = 1'b0;
  logic       rst_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decoder rules applied once per accepted byte.
  task automatic model_byte(input logic [7:0] b, output int es, output int er);
    es = 0;
    er = 0;
    if (b == 8'hF0) brk = 1'b1;
    else if (b != 8'hE0) begin
      if (brk) brk = 1'b0;
      else begin
        exp_in = b;
        es = (b == 8'h29) ? 1 : 0;
        er = (b == 8'h0D) ? 1 : 0;
      end
    end
  endtask

  // Per-cycle compare: value held outside the settling window, pulses one cycle and exclusive.
  always @(negedge clk) begin
    chk("both_pulses", {31'd0, set_signal & reset_signal}, 32'd0);
    chk("set_width", {31'd0, set_signal & set_prev}, 32'd0);
    chk("reset_width", {31'd0, reset_signal & rst_prev}, 32'd0);
    if (window) begin
      if (set_signal) set_cnt++;
      if (reset_signal) rst_cnt++;
    end else begin
      chk("hold_inForFSM", {24'd0, inForFSM}, {24'd0, exp_in});
      chk("idle_pulses", {30'd0, set_signal, reset_signal}, 32'd0);
    end
    set_prev = set_signal;
    rst_prev = reset_signal;
  end

  task automatic send_bit(input logic b);
    PS2_dat = b;
    #40 PS2_clk = 1'b0;
    #40 PS2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    int es, er;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    set_cnt = 0;
    rst_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      if (i == 10) window = 1'b1;
      send_bit(f[i]);
    end
    PS2_dat = 1'b1;
    #200;
    if (!bad_par && !bad_stop) model_byte(b, es, er);
    else begin
      es = 0;
      er = 0;
    end
    window = 1'b0;
    chk("frame_set_pulses", set_cnt, es);
    chk("frame_reset_pulses", rst_cnt, er);
    chk("frame_inForFSM", {24'd0, inForFSM}, {24'd0, exp_in});
  endtask

  task automatic press_release(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(b, 1'b0, 1'b0);
  endtask

  int tot_set, tot_rst;
  logic [7:0] seq [7];

  initial begin
    rst_n = 1'b0;
    PS2_clk = 1'b1;
    PS2_dat = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    chk("reset_inForFSM", {24'd0, inForFSM}, 32'h00);
    chk("reset_set", {31'd0, set_signal}, 32'd0);
    chk("reset_reset", {31'd0, reset_signal}, 32'd0);
    rst_n = 1'b1;
    #100;

    press_release(8'h5A);
    chk("lit_5a", {24'd0, inForFSM}, 32'h5A);
    press_release(8'h29);
    chk("lit_29", {24'd0, inForFSM}, 32'h29);
    press_release(8'h0D);
    chk("lit_0d", {24'd0, inForFSM}, 32'h0D);

    send_frame(8'h34, 1'b1, 1'b0);
    chk("lit_bad_parity", {24'd0, inForFSM}, 32'h0D);
    send_frame(8'h34, 1'b0, 1'b1);
    chk("lit_bad_stop", {24'd0, inForFSM}, 32'h0D);
    send_frame(8'h44, 1'b0, 1'b0);
    chk("lit_44", {24'd0, inForFSM}, 32'h44);

    // Typematic repeat and extended prefix.
    send_frame(8'h29, 1'b0, 1'b0);
    chk("lit_rep1_set", set_cnt, 32'd1);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0);
    chk("lit_rep2_set", set_cnt, 32'd1);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0);
    chk("lit_release_noset", set_cnt, 32'd0);

    seq = '{8'h5A, 8'h29, 8'h1B, 8'h0D, 8'h34, 8'h44, 8'h1B};
    tot_set = 0;
    tot_rst = 0;
    for (int i = 0; i < 7; i++) begin
      send_frame(seq[i], 1'b0, 1'b0);
      tot_set += set_cnt;
      tot_rst += rst_cnt;
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(seq[i], 1'b0, 1'b0);
      tot_set += set_cnt;
      tot_rst += rst_cnt;
    end
    chk("lit_seq_final", {24'd0, inForFSM}, 32'h1B);
    chk("lit_seq_sets", tot_set, 32'd1);
    chk("lit_seq_resets", tot_rst, 32'd1);

    // Reset in the middle of a frame for 29.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(logic'((8'h29 >> i) & 8'h01));
    rst_n = 1'b0;
    exp_in = 8'h00;
    brk = 1'b0;
    #60;
    chk("midreset_inForFSM", {24'd0, inForFSM}, 32'h00);
    rst_n = 1'b1;
    #100;
    send_frame(8'h1B, 1'b0, 1'b0);
    chk("lit_after_reset", {24'd0, inForFSM}, 32'h1B);
    chk("lit_after_reset_noset", set_cnt, 32'd0);

    // Stalled partial frame must time out before the next frame.
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    #(20 * 4300);
    send_frame(8'h0D, 1'b0, 1'b0);
    chk("lit_timeout_0d", {24'd0, inForFSM}, 32'h0D);
    chk("lit_timeout_reset", rst_cnt, 32'd1);

    for (int n = 0; n < 60; n++) begin
      logic [7:0] b;
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hF0;
        1: b = 8'hE0;
        2: b = 8'h29;
        3: b = 8'h0D;
        default: b = 8'($urandom);
      endcase
      send_frame(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
